counter_sweep_ctrl: RTL
=======================

COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 3, giving the controlled counter width.
REQ-002 The block SHALL have parameter DW, default 8, giving the dwell-count width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  async active-high reset.
REQ-004 The block SHALL have these control inputs: start  input  1  begin sweeping; stop  input  1  abort to IDLE; preset_load  input  1  load preset while idle; preset  input  N  preset value; dwell  input  DW  pause cycles at each end.
REQ-005 The block SHALL have these counter feedback inputs: max_tick  input  1  counter q at all-ones; min_tick  input  1  counter q at zero.
REQ-006 The block SHALL have these counter drive outputs: syn_clr  output  1  synchronous clear; load  output  1  parallel load; en  output  1  count enable; up  output  1  direction, 1=up; d  output  N  load value.
REQ-007 The block SHALL have these status outputs: busy  output  1  not IDLE; sweep_done  output  1  one-cycle pulse per completed up/down sweep; sweep_cnt  output  8  completed sweeps, modulo 256.

Function
REQ-008 The FSM SHALL have states IDLE, CLEAR, UP, DWELL_HI, DOWN and DWELL_LO, and the state register SHALL be the only source of the output decode, except for en (REQ-010).
REQ-009 Precedence SHALL be stop > start > preset_load; stop in any state SHALL force next state IDLE and en=0 in the same cycle.
REQ-010 en SHALL be: UP -> !max_tick & !stop; DOWN -> !min_tick & !stop; all other states -> 0, so the counter never wraps.
REQ-011 up SHALL be 1 in IDLE, CLEAR, UP and DWELL_LO, and 0 in DOWN and DWELL_HI.
REQ-012 In IDLE, start SHALL go to CLEAR; preset_load without start SHALL assert load=1 and d=preset for that cycle, staying in IDLE; otherwise load=0 and d holds its last value.
REQ-013 CLEAR SHALL last exactly one cycle with syn_clr=1, clear sweep_cnt to 0, then go to UP; syn_clr SHALL be 0 in all other states.
REQ-014 In UP, max_tick=1 SHALL go to DWELL_HI, or directly to DOWN if dwell=0; min_tick SHALL be ignored in UP.
REQ-015 In DOWN, min_tick=1 SHALL pulse sweep_done for one cycle, increment sweep_cnt with wrap from 255 to 0, then go to DWELL_LO, or directly to UP if dwell=0; max_tick SHALL be ignored in DOWN.
REQ-016 dwell SHALL be sampled on entry to DWELL_HI/DWELL_LO, each dwell state SHALL last exactly dwell cycles, and changes to dwell mid-dwell SHALL have no effect.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 busy SHALL be 1 in every state except IDLE.

Reset
REQ-019 Reset SHALL act immediately regardless of clk, including mid-sweep: state=IDLE, syn_clr=0, load=0, en=0, up=1, d=0, busy=0, sweep_done=0, sweep_cnt=0, dwell counter=0.

Verification (N=3, driving a 3-bit universal up/down counter)
REQ-020 Bench SHALL cover: dwell=2, start pulse -> syn_clr=1 one cycle; q 0->7 over 7 enabled cycles; en=0 while q=7 for 1+2 cycles; q 7->0; sweep_done pulse; sweep_cnt=1.
REQ-021 Bench SHALL cover: dwell=0, running -> exactly one en=0 cycle at q=7 and one at q=0; up toggles; q never wraps 7->0 or 0->7.
REQ-022 Bench SHALL cover: IDLE, preset_load=1, preset=5 -> load=1, d=5 for one cycle; counter q=5; busy stays 0.
REQ-023 Bench SHALL cover: stop during DWELL_HI with sweep_cnt=3 -> IDLE next cycle, busy=0, en=0, sweep_cnt stays 3.
REQ-024 Bench SHALL cover: start and stop asserted together in IDLE, then start asserted during UP -> stays IDLE, then no effect (no syn_clr).
REQ-025 Bench SHALL cover: reset asserted mid-DOWN between clock edges -> all outputs at REQ-019 values before the next clk edge.

Source files
------------

// File: rtl/counter_sweep_ctrl_if.sv
// Control, counter-feedback, counter-drive and status signals of the sweep controller.
// master drives the controller inputs; slave is the controller itself.
interface counter_sweep_ctrl_if #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8
);
  logic          start;
  logic          stop;
  logic          preset_load;
  logic [N-1:0]  preset;
  logic [DW-1:0] dwell;
  logic          max_tick;
  logic          min_tick;
  logic          syn_clr;
  logic          load;
  logic          en;
  logic          up;
  logic [N-1:0]  d;
  logic          busy;
  logic          sweep_done;
  logic [7:0]    sweep_cnt;

  modport master (
    output start, stop, preset_load, preset, dwell, max_tick, min_tick,
    input  syn_clr, load, en, up, d, busy, sweep_done, sweep_cnt
  );

  modport slave (
    input  start, stop, preset_load, preset, dwell, max_tick, min_tick,
    output syn_clr, load, en, up, d, busy, sweep_done, sweep_cnt
  );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Drives an external up/down counter through repeated 0 -> max -> 0 sweeps,
// pausing a programmable number of cycles at each end and counting sweeps.
module counter_sweep_ctrl #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8
) (
  input logic                  clk,
  input logic                  reset,
  counter_sweep_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StUp,
    StDwellHi,
    StDown,
    StDwellLo
  } state_e;

  state_e        state_q;
  logic          load_q;
  logic [N-1:0]  d_q;
  logic          sweep_done_q;
  logic [7:0]    sweep_cnt_q;
  logic [DW-1:0] dwell_q;
  logic          en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      load_q       <= 1'b0;
      d_q          <= '0;
      sweep_done_q <= 1'b0;
      sweep_cnt_q  <= '0;
      dwell_q      <= '0;
    end else begin
      load_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      if (bus.stop) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              state_q <= StClear;
            end else if (bus.preset_load) begin
              load_q <= 1'b1;
              d_q    <= bus.preset;
            end
          end
          StClear: begin
            sweep_cnt_q <= '0;
            state_q     <= StUp;
          end
          StUp: begin
            if (bus.max_tick) begin
              if (bus.dwell == '0) begin
                state_q <= StDown;
              end else begin
                dwell_q <= bus.dwell;
                state_q <= StDwellHi;
              end
            end
          end
          StDwellHi: begin
            // dwell_q holds the remaining cycles including this one
            dwell_q <= dwell_q - 1'b1;
            if (dwell_q == DW'(1)) state_q <= StDown;
          end
          StDown: begin
            if (bus.min_tick) begin
              sweep_done_q <= 1'b1;
              sweep_cnt_q  <= sweep_cnt_q + 8'd1;
              if (bus.dwell == '0) begin
                state_q <= StUp;
              end else begin
                dwell_q <= bus.dwell;
                state_q <= StDwellLo;
              end
            end
          end
          StDwellLo: begin
            dwell_q <= dwell_q - 1'b1;
            if (dwell_q == DW'(1)) state_q <= StUp;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Enable is gated by the end ticks so the counter can never wrap.
  always_comb begin
    en = 1'b0;
    case (state_q)
      StUp:    en = !bus.max_tick && !bus.stop;
      StDown:  en = !bus.min_tick && !bus.stop;
      default: en = 1'b0;
    endcase
  end

  assign bus.en         = en;
  assign bus.syn_clr    = (state_q == StClear);
  assign bus.up         = !((state_q == StDown) || (state_q == StDwellHi));
  assign bus.busy       = (state_q != StIdle);
  assign bus.load       = load_q;
  assign bus.d          = d_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.sweep_cnt  = sweep_cnt_q;

endmodule
